// File: rtl/alu_exec_stage.sv
// Two-register execute stage around a combinational ALU: operand register S1,
// result register S2, valid/ready on both sides, plus a consume counter and sticky overflow.

package alu_types_pkg;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_control_t;
endpackage

module alu
  import alu_types_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_control_t control,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic         zero,
  output logic         equal
);
  logic [N-1:0] sum;
  logic [N-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Signed overflow: operands agree (add) or differ (sub) in sign and the result sign flips.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_ADD: begin
        result   = sum;
        overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      ALU_SLT: result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero  = (result == '0);
  assign equal = (a == b);
endmodule

module alu_exec_stage
  import alu_types_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  alu_control_t     in_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_equal,
  output alu_control_t     out_control,
  input  logic             clear_status,
  output logic [CNT_W-1:0] op_count,
  output logic             overflow_sticky
);
  logic         s1_valid;
  logic [N-1:0] s1_a;
  logic [N-1:0] s1_b;
  alu_control_t s1_control;

  logic         s2_valid;
  logic [N-1:0] s2_result;
  logic         s2_overflow;
  logic         s2_zero;
  logic         s2_equal;
  alu_control_t s2_control;

  logic [N-1:0] alu_result;
  logic         alu_overflow;
  logic         alu_zero;
  logic         alu_equal;

  logic             s2_load_ok;
  logic             accept;
  logic             transfer;
  logic             consume;
  logic [CNT_W-1:0] count_base;
  logic             sticky_base;

  // No skid buffer, so in_ready looks straight through to out_ready.
  assign s2_load_ok = !s2_valid || out_ready;
  assign in_ready   = !rst && (!s1_valid || s2_load_ok);
  assign accept     = in_valid && in_ready;
  assign transfer   = s1_valid && s2_load_ok;
  assign consume    = s2_valid && out_ready;

  alu #(.N(N)) u_alu (
    .a        (s1_a),
    .b        (s1_b),
    .control  (s1_control),
    .result   (alu_result),
    .overflow (alu_overflow),
    .zero     (alu_zero),
    .equal    (alu_equal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_control <= ALU_AND;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_a       <= in_a;
      s1_b       <= in_b;
      s1_control <= in_control;
    end else if (transfer) begin
      s1_valid <= 1'b0;
    end
  end

  // Payload only moves on a load, which keeps it stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      s2_result   <= '0;
      s2_overflow <= 1'b0;
      s2_zero     <= 1'b0;
      s2_equal    <= 1'b0;
      s2_control  <= ALU_AND;
    end else if (transfer) begin
      s2_valid    <= 1'b1;
      s2_result   <= alu_result;
      s2_overflow <= alu_overflow;
      s2_zero     <= alu_zero;
      s2_equal    <= alu_equal;
      s2_control  <= s1_control;
    end else if (consume) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid    = s2_valid;
  assign out_result   = s2_result;
  assign out_overflow = s2_overflow;
  assign out_zero     = s2_zero;
  assign out_equal    = s2_equal;
  assign out_control  = s2_control;

  // A clear lands before a same-cycle consume, so that beat is still counted.
  always_comb begin
    count_base  = clear_status ? '0 : op_count;
    sticky_base = !clear_status && overflow_sticky;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count        <= '0;
      overflow_sticky <= 1'b0;
    end else begin
      op_count        <= consume ? count_base + CNT_W'(1) : count_base;
      overflow_sticky <= sticky_base || (consume && s2_overflow);
    end
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: latency, streaming, backpressure, reset flush,
// status clear collision and counter wrap, checked against a bench-side ALU model.

module tb_alu_exec_stage;
  import alu_types_pkg::*;

  typedef struct {
    logic [31:0]  a;
    logic [31:0]  b;
    alu_control_t ctl;
  } beat_t;

  localparam longint MaxS = 64'sh7FFF_FFFF;
  localparam longint MinS = -64'sh8000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_a = '0;
  logic [31:0]  in_b = '0;
  alu_control_t in_control = ALU_AND;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_result;
  logic         out_overflow;
  logic         out_zero;
  logic         out_equal;
  alu_control_t out_control;
  logic         clear_status = 1'b0;
  logic [15:0]  op_count;
  logic         overflow_sticky;

  logic         w4_in_ready;
  logic         w4_out_valid;
  logic [31:0]  w4_out_result;
  logic         w4_out_overflow;
  logic         w4_out_zero;
  logic         w4_out_equal;
  alu_control_t w4_out_control;
  logic [3:0]   w4_op_count;
  logic         w4_overflow_sticky;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int first_accept = -1;
  int first_consume = -1;
  int last_consume = -1;
  logic last_in_ready = 1'b0;

  beat_t       pend_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] ops[9];

  always #5 clk = ~clk;

  alu_exec_stage #(.N(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_control(in_control),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow),
    .out_zero(out_zero), .out_equal(out_equal), .out_control(out_control),
    .clear_status(clear_status), .op_count(op_count),
    .overflow_sticky(overflow_sticky)
  );

  // Same stimulus into a narrow-counter copy to see the wrap.
  alu_exec_stage #(.N(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(w4_in_ready),
    .in_a(in_a), .in_b(in_b), .in_control(in_control),
    .out_valid(w4_out_valid), .out_ready(out_ready),
    .out_result(w4_out_result), .out_overflow(w4_out_overflow),
    .out_zero(w4_out_zero), .out_equal(w4_out_equal), .out_control(w4_out_control),
    .clear_status(clear_status), .op_count(w4_op_count),
    .overflow_sticky(w4_overflow_sticky)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic beat_t mkBeat(input logic [31:0] a, input logic [31:0] b, input alu_control_t ctl);
    beat_t bt;
    bt.a = a;
    bt.b = b;
    bt.ctl = ctl;
    return bt;
  endfunction

  // Reference ALU in 64-bit signed arithmetic; packed as {ctl, ov, zero, equal, result}.
  function automatic logic [63:0] aluModel(input beat_t bt);
    longint sa, sb, wide;
    logic [31:0] r;
    logic ov;
    sa = longint'($signed(bt.a));
    sb = longint'($signed(bt.b));
    wide = 0;
    r = '0;
    ov = 1'b0;
    case (bt.ctl)
      ALU_AND: r = bt.a & bt.b;
      ALU_OR:  r = bt.a | bt.b;
      ALU_NOR: r = ~(bt.a | bt.b);
      ALU_ADD: begin wide = sa + sb; r = wide[31:0]; ov = (wide > MaxS) || (wide < MinS); end
      ALU_SUB: begin wide = sa - sb; r = wide[31:0]; ov = (wide > MaxS) || (wide < MinS); end
      ALU_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {25'b0, bt.ctl, ov, (r == 32'd0), (bt.a == bt.b), r};
  endfunction

  function automatic logic [63:0] obsPack();
    return {25'b0, out_control, out_overflow, out_zero, out_equal, out_result};
  endfunction

  // One clock of traffic: offer the head of pend_q, score any consume, record any accept.
  task automatic applyStimulus(input logic rdy, input string tag);
    beat_t bt;
    in_valid = (pend_q.size() > 0);
    if (in_valid) begin
      bt = pend_q[0];
      in_a = bt.a;
      in_b = bt.b;
      in_control = bt.ctl;
    end
    out_ready = rdy;
    #1;
    last_in_ready = in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput({tag, "_unexpected_out"}, 64'(out_valid), 64'd0);
      end else begin
        checkOutput(tag, obsPack(), exp_q.pop_front());
      end
      if (first_consume < 0) first_consume = cyc;
      last_consume = cyc;
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(aluModel(bt));
      void'(pend_q.pop_front());
      if (first_accept < 0) first_accept = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runPipe(input int max_cycles, input string tag);
    int n = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && n < max_cycles) begin
      applyStimulus(1'b1, tag);
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput({tag, "_drained"}, 64'(exp_q.size() + pend_q.size()), 64'd0);
  endtask

  task automatic clearAlone();
    clear_status = 1'b1;
    @(posedge clk);
    #1;
    clear_status = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ops = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0005, 32'h7FFF_FFFF, 32'h8000_0000,
            32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFE, 32'h4000_0000};

    // Reset state
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_payload", obsPack(), 64'd0);
    checkOutput("rst_op_count", 64'(op_count), 64'd0);
    checkOutput("rst_sticky", 64'(overflow_sticky), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single overflowing ADD, 2-cycle latency
    in_valid = 1'b1;
    in_a = 32'h7FFF_FFFF;
    in_b = 32'h0000_0001;
    in_control = ALU_ADD;
    #1;
    checkOutput("add_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    checkOutput("add_lat1_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("add_lat2_valid", 64'(out_valid), 64'd1);
    checkOutput("add_payload", obsPack(), {25'b0, 4'b0010, 3'b100, 32'h8000_0000});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("add_op_count", 64'(op_count), 64'd1);
    checkOutput("add_sticky", 64'(overflow_sticky), 64'd1);
    checkOutput("add_drained_valid", 64'(out_valid), 64'd0);

    // Streaming 81 SUB beats
    clearAlone();
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 9; j++)
        pend_q.push_back(mkBeat(ops[i], ops[j], ALU_SUB));
    first_accept = -1;
    first_consume = -1;
    last_consume = -1;
    runPipe(300, "stream");
    checkOutput("stream_latency", 64'(first_consume - first_accept), 64'd2);
    checkOutput("stream_rate", 64'(last_consume - first_consume), 64'd80);
    checkOutput("stream_op_count", 64'(op_count), 64'd81);

    // Backpressure: offer 4 beats with out_ready low
    pend_q.push_back(mkBeat(32'd10, 32'd3, ALU_ADD));
    pend_q.push_back(mkBeat(32'd7, 32'd7, ALU_SUB));
    pend_q.push_back(mkBeat(32'hF0F0_0000, 32'h0F0F_0000, ALU_OR));
    pend_q.push_back(mkBeat(32'hFFFF_FFFF, 32'd1, ALU_SLT));
    applyStimulus(1'b0, "bp");
    applyStimulus(1'b0, "bp");
    checkOutput("bp_accepted", 64'(exp_q.size()), 64'd2);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, "bp");
      checkOutput("bp_in_ready_low", 64'(last_in_ready), 64'd0);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_hold", obsPack(), exp_q[0]);
    end
    applyStimulus(1'b1, "bp");
    checkOutput("bp_release_ready", 64'(last_in_ready), 64'd1);
    runPipe(50, "bp");
    checkOutput("bp_op_count", 64'(op_count), 64'd85);

    // Reset with both stages full
    pend_q.push_back(mkBeat(32'd1, 32'd2, ALU_ADD));
    pend_q.push_back(mkBeat(32'd3, 32'd4, ALU_ADD));
    applyStimulus(1'b0, "flush");
    applyStimulus(1'b0, "flush");
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("flush_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_op_count", 64'(op_count), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, "flush");
      checkOutput("flush_no_out", 64'(out_valid), 64'd0);
    end
    checkOutput("flush_op_count_after", 64'(op_count), 64'd0);

    // Clear colliding with an overflowing consume at op_count=5
    for (int k = 0; k < 5; k++)
      pend_q.push_back(mkBeat(32'(k), 32'hFFFF_FFFF, ALU_AND));
    runPipe(50, "clr_pre");
    checkOutput("clr_pre_count", 64'(op_count), 64'd5);
    checkOutput("clr_pre_sticky", 64'(overflow_sticky), 64'd0);
    pend_q.push_back(mkBeat(32'h8000_0000, 32'h0000_0001, ALU_SUB));
    applyStimulus(1'b0, "clr");
    applyStimulus(1'b0, "clr");
    in_valid = 1'b0;
    clear_status = 1'b1;
    applyStimulus(1'b1, "clr");
    clear_status = 1'b0;
    out_ready = 1'b0;
    checkOutput("clr_collide_count", 64'(op_count), 64'd1);
    checkOutput("clr_collide_sticky", 64'(overflow_sticky), 64'd1);
    clearAlone();
    checkOutput("clr_alone_count", 64'(op_count), 64'd0);
    checkOutput("clr_alone_sticky", 64'(overflow_sticky), 64'd0);

    // Narrow counter wrap after 17 consumes
    for (int k = 0; k < 17; k++)
      pend_q.push_back(mkBeat(32'(k), 32'd100, ALU_ADD));
    runPipe(100, "wrap");
    checkOutput("wrap_cnt4", 64'(w4_op_count), 64'd1);
    checkOutput("wrap_cnt16", 64'(op_count), 64'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage wrapping the combinational `alu`. It accepts operand/control beats from the decode/register-read logic over a valid/ready handshake, runs them through one `alu` instance, and presents registered result and flags to writeback over a second valid/ready handshake. Two pipeline registers give 2-cycle latency and full throughput. It also keeps a small status block (operation counter, sticky overflow) for bench and debug visibility.

## Interface
- `N`, 32: data width; only 32 is supported.
- `CNT_W`, 16: width of `op_count`.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  stage can accept a beat this cycle.
- `in_a`  in  N  operand A.
- `in_b`  in  N  operand B.
- `in_control`  in  `alu_control_t`  ALU operation (type from `alu_types.sv`).
- `out_valid`  out  1  registered result valid.
- `out_ready`  in  1  downstream accepts the result this cycle.
- `out_result`  out  N  registered `alu` result.
- `out_overflow`, `out_zero`, `out_equal`  out  1 each  registered `alu` flags.
- `out_control`  out  `alu_control_t`  operation that produced `out_result`.
- `clear_status`  in  1  synchronous clear of the status block.
- `op_count`  out  CNT_W  number of results consumed downstream (wraps).
- `overflow_sticky`  out  1  set when any consumed result had overflow.

## Operation
- S1 (operand register): holds `s1_valid`, a, b, control. Loads when `in_valid && in_ready`.
- The `alu` is driven combinationally from S1.
- S2 (result register): holds `s2_valid`, result, flags, control. Loads from S1/`alu` when `s1_valid && s2_load_ok`.
- `s2_load_ok = !s2_valid || out_ready`.
- `in_ready = !rst && (!s1_valid || s2_load_ok)`. This path is combinational from `out_ready`; there is no skid buffer.
- Register updates:
  - S1 empties when it transfers to S2 without a new accept.
  - S2 empties on `out_valid && out_ready` when S1 is not transferring.
  - A simultaneous accept and transfer keeps each stage full with new data.
- The data registers of an invalid stage hold their previous contents, so outputs only change on a load.
- Handshake: `out_valid` and all `out_*` payload stay stable while `out_valid && !out_ready`. The upstream side likewise holds its payload until `in_ready`.
- Status block:
  - Consume event = `out_valid && out_ready`.
  - On a consume, `op_count` increments modulo 2^CNT_W. 0xFFFF + 1 = 0x0000.
  - On a consume with `out_overflow`, `overflow_sticky` sets.
  - `clear_status` and a consume in the same cycle: clear applies first, then the event. Result is `op_count = 1`, and `overflow_sticky` equals that beat's overflow.
- Flags are those of `alu`, captured unmodified. Overflow applies only to ADD/SUB, per `alu`.

## Timing
- Reset (synchronous, `rst` high at a rising edge):
  - Cleared to 0: `s1_valid`, `s2_valid`, all data registers, `op_count`, `overflow_sticky`.
  - `out_valid` = 0 and all `out_*` = 0.
  - `in_ready` = 0 while `rst` is high, 1 in the first cycle after reset.
- Reset mid-operation flushes both stages. In-flight beats are dropped and never counted.
- Latency: a beat accepted at edge T is in S1 after T and in S2 after T+1, so `out_valid` is high in the cycle following edge T+1. Latency is 2 cycles.
- Throughput: 1 beat/cycle with `out_ready` held high.
- Backpressure:
  - With `out_ready` low, the stage absorbs at most 2 beats.
  - `in_ready` falls in the same cycle that S1 and S2 are both full and `out_ready` is 0.
  - After `out_ready` rises, `in_ready` rises combinationally in that same cycle.
- `op_count` and `overflow_sticky` update at the edge that completes the consume and are visible the next cycle.

## Test plan
- **Reset then single ADD.** Stimulus: `a=0x7FFFFFFF`, `b=0x00000001`, ADD. Required: `out_valid` exactly 2 cycles after accept; `out_result=0x80000000`, `out_overflow=1`, `out_zero=0`, `out_equal=0`. After consume: `op_count=1`, `overflow_sticky=1`.
- **Streaming.** Stimulus: 81 back-to-back beats (SUB over the 9×9 operand set of the ALU bench), `out_ready=1`. Required: one result per cycle, in order, each matching `alu_behavioural` (e.g. SUB 5−5 gives result 0, zero=1, equal=1). Final `op_count=81`.
- **Backpressure.** Hold `out_ready=0` while offering 4 beats. Required: exactly 2 accepted, `in_ready=0` from then on, output payload stable. Release `out_ready`: both results drain in order and the remaining beats follow with no loss or duplication.
- **Reset mid-flight.** Assert `rst` for 1 cycle with S1 and S2 full. Required: next cycle `out_valid=0`, `op_count=0`, `in_ready=1`; the dropped beats never appear at the output.
- **Status clear collision.** Assert `clear_status` in the same cycle as a consume with overflow=1 while `op_count=5`. Required: `op_count=1`, `overflow_sticky=1`. Clear alone: both become 0.
- **Counter wrap.** Use `CNT_W=4` and 17 consumes. Required: `op_count=1`.
